// File: rtl/fix_pkg.sv
// Shared definitions for the c2w fixed-point stages.
package fix_pkg;
  localparam int FIX_DATA_W = 32;
  localparam int FIX_FRAC_W = 16;

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_e;

  // Q16.16 constants
  localparam logic [31:0] FIX_ONE = 32'h0001_0000;
  localparam logic [31:0] FIX_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] FIX_MIN = 32'h8000_0000;
endpackage

// File: rtl/fix_acc_if.sv
// Input and output stream handshakes of the accumulator.
interface fix_acc_if
  import fix_pkg::*;
#(
  parameter int DATA_W = FIX_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fix_sat.sv
// Combinational signed clamp from IN_W to OUT_W bits with a saturation flag.
module fix_sat #(
  parameter int IN_W  = 36,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             sat
);
  // The value fits when every bit from the output sign bit upward agrees.
  logic [IN_W-OUT_W:0] top;
  assign top = din[IN_W-1:OUT_W-1];

  // Clamp toward the rail on the side of the input sign.
  always_comb begin
    sat = ~((&top) | ~(|top));
    if (!sat)
      dout = din[OUT_W-1:0];
    else if (din[IN_W-1])
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    else
      dout = {1'b0, {(OUT_W-1){1'b1}}};
  end
endmodule

// File: rtl/fix_acc.sv
// Frame accumulator: sums up to LEN signed samples in a widened register
// and presents the saturated total on a valid/ready output.
module fix_acc
  import fix_pkg::*;
#(
  parameter int DATA_W = FIX_DATA_W,
  parameter int FRAC_W = FIX_FRAC_W,
  parameter int LEN    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  fix_acc_if.slave   bus
);
  // Headroom of clog2(LEN) bits means a frame can never wrap internally.
  localparam int CNT_W = $clog2(LEN);
  localparam int ACC_W = DATA_W + CNT_W;

  // FRAC_W only documents the binary point; the sum is not rescaled.
  if (LEN < 2 || FRAC_W >= DATA_W) begin : g_param_chk
    $error("fix_acc: LEN must be >= 2 and FRAC_W < DATA_W");
  end

  state_e             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               accept, frame_end;
  logic [DATA_W-1:0]  sat_data, out_data_q;
  logic               sat_flag, out_sat_q;

  assign accept    = bus.in_valid & (state == ACC);
  assign acc_nxt   = acc + {{(ACC_W-DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};
  assign frame_end = accept & (bus.in_last | (cnt == CNT_W'(LEN-1)));

  fix_sat #(.IN_W(ACC_W), .OUT_W(DATA_W)) u_sat (
    .din  (acc_nxt),
    .dout (sat_data),
    .sat  (sat_flag)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  // Next state: clr wins over both the closing beat and out_ready.
  always_comb begin
    state_nxt = state;
    if (clr)
      state_nxt = ACC;
    else if (state == ACC && frame_end)
      state_nxt = HOLD;
    else if (state == HOLD && bus.out_ready)
      state_nxt = ACC;
  end

  // Handshake outputs depend on state only, so out_ready never reaches in_ready.
  always_comb begin
    bus.in_ready  = (state == ACC);
    bus.out_valid = (state == HOLD);
  end

  // Accumulator, beat counter and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (frame_end) begin
      acc        <= '0;
      cnt        <= '0;
      out_data_q <= sat_data;
      out_sat_q  <= sat_flag;
    end else if (accept) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.out_data = out_data_q;
  assign bus.out_sat  = out_sat_q;
endmodule

// File: tb/tb_fix_acc.sv
// Self-checking bench for fix_acc with LEN=4: directed frames plus random traffic
// against a frame-level reference model.
module tb_fix_acc;
  localparam int LEN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fix_acc_if #(.DATA_W(32)) bus ();

  fix_acc #(.DATA_W(32), .FRAC_W(16), .LEN(LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus.slave)
  );

  // Reference model: beats of the open frame, whether a result is pending,
  // and the last delivered result.
  int          m_q[$];
  bit          m_hold = 1'b0;
  logic [31:0] m_data = '0;
  logic        m_sat  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(!m_hold));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_hold));
    chk({tag, ".out_data"},  bus.out_data,       m_data);
    chk({tag, ".out_sat"},   32'(bus.out_sat),   32'(m_sat));
  endtask

  // Close the frame: exact integer sum, then clamp to the 32-bit range.
  task automatic model_close();
    longint s = 0;
    foreach (m_q[i]) s += longint'(m_q[i]);
    if (s > 64'sd2147483647) begin
      m_data = 32'h7FFF_FFFF; m_sat = 1'b1;
    end else if (s < -64'sd2147483648) begin
      m_data = 32'h8000_0000; m_sat = 1'b1;
    end else begin
      m_data = s[31:0]; m_sat = 1'b0;
    end
    m_q.delete();
    m_hold = 1'b1;
  endtask

  // One clock: drive inputs, advance the model, check just after the edge.
  task automatic step(input string tag, input logic v, input logic [31:0] d,
                      input logic l, input logic ordy, input logic c);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
    clr           = c;
    if (c) begin
      m_q.delete();
      m_hold = 1'b0;
    end else if (!m_hold) begin
      if (v) begin
        m_q.push_back(int'(d));
        if (l || m_q.size() == LEN) model_close();
      end
    end else if (ordy) begin
      m_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_rst(input string tag);
    bus.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk({tag, ".rst_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".rst_out_data"},  bus.out_data,       32'd0);
    chk({tag, ".rst_out_sat"},   32'(bus.out_sat),   32'd0);
    m_q.delete();
    m_hold = 1'b0;
    m_data = '0;
    m_sat  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step({tag, ".post"}, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] r, d;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.out_data",  bus.out_data,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("reset", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);

    // Four beats without in_last close on the count limit
    step("f1.b0", 1'b1, 32'h0001_0000, 1'b0, 1'b1, 1'b0);
    step("f1.b1", 1'b1, 32'h0002_0000, 1'b0, 1'b1, 1'b0);
    step("f1.b2", 1'b1, 32'hFFFF_8000, 1'b0, 1'b1, 1'b0);
    step("f1.b3", 1'b1, 32'h0000_4000, 1'b0, 1'b1, 1'b0);
    chk("f1.result", bus.out_data, 32'h0002_C000);
    chk("f1.valid",  32'(bus.out_valid), 32'd1);
    step("f1.hold", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

    // Short frame closed by in_last, then a fresh single-beat frame
    step("f2.b0", 1'b1, 32'h0003_0000, 1'b0, 1'b1, 1'b0);
    step("f2.b1", 1'b1, 32'h0001_0000, 1'b1, 1'b1, 1'b0);
    chk("f2.result", bus.out_data, 32'h0004_0000);
    step("f2.hold", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    step("f3.b0", 1'b1, 32'h0000_4000, 1'b1, 1'b1, 1'b0);
    chk("f3.result", bus.out_data, 32'h0000_4000);
    step("f3.hold", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

    // Positive and negative saturation
    for (int i = 0; i < 4; i++) step("sat_hi", 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    chk("sat_hi.data", bus.out_data, 32'h7FFF_FFFF);
    chk("sat_hi.flag", 32'(bus.out_sat), 32'd1);
    step("sat_hi.hold", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("sat_lo", 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    chk("sat_lo.data", bus.out_data, 32'h8000_0000);
    chk("sat_lo.flag", 32'(bus.out_sat), 32'd1);
    step("sat_lo.hold", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

    // Backpressure in HOLD: offered beats are not consumed
    step("bp.b0", 1'b1, 32'h0005_0000, 1'b1, 1'b0, 1'b0);
    held = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      step("bp.stall", 1'b1, 32'h0100_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
      chk("bp.stable", bus.out_data, held);
      chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
    end
    step("bp.release", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("bp.in_ready_back", 32'(bus.in_ready), 32'd1);

    // clr mid-frame discards the partial sum
    step("clr.b0", 1'b1, 32'h0001_0000, 1'b0, 1'b1, 1'b0);
    step("clr.b1", 1'b1, 32'h0001_0000, 1'b0, 1'b1, 1'b0);
    step("clr.pulse", 1'b1, 32'h0001_0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step("clr.frame", 1'b1, 32'h0001_0000, 1'b0, 1'b1, 1'b0);
    chk("clr.result", bus.out_data, 32'h0004_0000);
    // clr in HOLD drops the pending result even with out_ready low
    step("clr.hold", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("clr.drop", 32'(bus.out_valid), 32'd0);

    // Async reset mid-frame and in HOLD
    step("rst.b0", 1'b1, 32'h0002_0000, 1'b0, 1'b1, 1'b0);
    async_rst("rst_mid");
    step("rst.f0", 1'b1, 32'h0001_0000, 1'b1, 1'b0, 1'b0);
    async_rst("rst_hold");
    step("rst.f1", 1'b1, 32'h0001_0000, 1'b1, 1'b1, 1'b0);
    chk("rst.first_frame", bus.out_data, 32'h0001_0000);
    step("rst.f1.hold", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      case (r[1:0])
        2'd0:    d = $urandom;
        2'd1:    d = 32'h7FFF_FFFF - 32'($urandom_range(0, 255));
        2'd2:    d = 32'h8000_0000 + 32'($urandom_range(0, 255));
        default: begin d = $urandom; d = {{16{d[15]}}, d[15:0]}; end
      endcase
      step("rand", r[4:2] != 3'd0, d, r[7:5] == 3'd0, r[9:8] != 2'd0, r[15:10] == 6'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
